// File: rtl/fc_backprop_engine.sv
// fc_backprop_engine: backward pass of a square fully connected layer.
// Computes err_in[i] = sum_j W[i][j] * err_out[j] with one shared MAC,
// one product per clock, L*L clocks per vector. Weight packing matches the
// forward layer: W[i][j] at weight_vector[(i*L+j)*DATA_WIDTH +: DATA_WIDTH].
// Optional feature macro: FC_BP_SATURATE_EN clamps each result to the largest
// unsigned DATA_WIDTH value instead of wrapping.
//
// Handshake: start is sampled only while idle (busy=0); a start seen in any
// other state is dropped, not queued. Operands are latched on the accepting
// edge. done pulses high for exactly one cycle, and during that cycle
// err_in_vector holds the fresh result. err_in_vector changes on no other edge.
module fc_backprop_engine #(
  parameter int DATA_WIDTH  = 4,
  parameter int LAYER_WIDTH = 2
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic [DATA_WIDTH*LAYER_WIDTH*LAYER_WIDTH-1:0] weight_vector,
  input  logic [DATA_WIDTH*LAYER_WIDTH-1:0]          err_out_vector,
  output logic                                       busy,
  output logic                                       done,
  output logic [DATA_WIDTH*LAYER_WIDTH-1:0]          err_in_vector
);

  localparam int L         = LAYER_WIDTH;
  localparam int ACC_WIDTH = 2*DATA_WIDTH + $clog2(LAYER_WIDTH) + 1;
  localparam int PROD_W    = 2*DATA_WIDTH;
  localparam int CNT_W     = (L > 1) ? $clog2(L) : 1;
  localparam int W_BITS    = DATA_WIDTH*L*L;
  localparam int V_BITS    = DATA_WIDTH*L;
  localparam logic [ACC_WIDTH-1:0] ELEM_MAX = ACC_WIDTH'({DATA_WIDTH{1'b1}});

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [W_BITS-1:0]      w_q, w_d;
  logic [V_BITS-1:0]      e_q, e_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]       i_q, i_d;
  logic [CNT_W-1:0]       j_q, j_d;
  logic [V_BITS-1:0]      buf_q, buf_d;
  logic [V_BITS-1:0]      err_in_q, err_in_d;
  logic                   done_q, done_d;

  logic [DATA_WIDTH-1:0]  w_sel;
  logic [DATA_WIDTH-1:0]  e_sel;
  logic [PROD_W-1:0]      prod;
  logic [ACC_WIDTH-1:0]   acc_sum;
  logic [DATA_WIDTH-1:0]  elem;
  logic                   last_i;
  logic                   last_j;

  // Select the current operands W[i][j] and err_out[j] from the latched copies
  always_comb begin
    w_sel = '0;
    e_sel = '0;
    for (int ii = 0; ii < L; ii++) begin
      for (int jj = 0; jj < L; jj++) begin
        if (i_q == CNT_W'(ii) && j_q == CNT_W'(jj)) begin
          w_sel = w_q[(ii*L+jj)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
    for (int jj = 0; jj < L; jj++) begin
      if (j_q == CNT_W'(jj)) begin
        e_sel = e_q[jj*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Multiply-accumulate and reduce the running sum to an output element
  always_comb begin
    prod    = PROD_W'(w_sel) * PROD_W'(e_sel);
    acc_sum = acc_q + ACC_WIDTH'(prod);
    last_i  = (i_q == CNT_W'(L-1));
    last_j  = (j_q == CNT_W'(L-1));
`ifdef FC_BP_SATURATE_EN
    if (acc_sum > ELEM_MAX) begin
      elem = '1;
    end else begin
      elem = acc_sum[DATA_WIDTH-1:0];
    end
`else
    elem = acc_sum[DATA_WIDTH-1:0];
`endif
  end

  // Next-state and datapath control: IDLE -> MAC -> DONE -> IDLE
  always_comb begin
    state_d  = state_q;
    w_d      = w_q;
    e_d      = e_q;
    acc_d    = acc_q;
    i_d      = i_q;
    j_d      = j_q;
    buf_d    = buf_q;
    err_in_d = err_in_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d     = weight_vector;
          e_d     = err_out_vector;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        if (last_j) begin
          // Row i finished: park its element, start the next row
          for (int ii = 0; ii < L; ii++) begin
            if (i_q == CNT_W'(ii)) begin
              buf_d[ii*DATA_WIDTH +: DATA_WIDTH] = elem;
            end
          end
          acc_d = '0;
          j_d   = '0;
          if (last_i) begin
            // Publish the whole buffer, including the element just produced
            err_in_d = buf_d;
            done_d   = 1'b1;
            i_d      = '0;
            state_d  = S_DONE;
          end else begin
            i_d = i_q + CNT_W'(1);
          end
        end else begin
          acc_d = acc_sum;
          j_d   = j_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      w_q      <= '0;
      e_q      <= '0;
      acc_q    <= '0;
      i_q      <= '0;
      j_q      <= '0;
      buf_q    <= '0;
      err_in_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      w_q      <= w_d;
      e_q      <= e_d;
      acc_q    <= acc_d;
      i_q      <= i_d;
      j_q      <= j_d;
      buf_q    <= buf_d;
      err_in_q <= err_in_d;
      done_q   <= done_d;
    end
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err_in_vector = err_in_q;

endmodule
